// File: rtl/io_intr_ctrl.sv
// I/O interrupt controller: edge-detected external requests plus a periodic timer,
// masked and prioritised (lowest index wins), presented to the CPU with an intr/int_ack handshake.
module io_intr_ctrl #(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned TMR_W   = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 io_cs,
  input  logic                 io_rd,
  input  logic                 io_wr,
  input  logic [31:0]          addr,
  input  logic [31:0]          D_in_IO,
  output logic [31:0]          D_out_IO,
  input  logic [NUM_SRC-2:0]   irq_in,
  input  logic                 int_ack,
  output logic                 intr,
  output logic [4:0]           vector
);

  localparam int unsigned VEC_W = 5;
  localparam logic [2:0] A_PEND  = 3'd0;
  localparam logic [2:0] A_MASK  = 3'd1;
  localparam logic [2:0] A_CLR   = 3'd2;
  localparam logic [2:0] A_VEC   = 3'd3;
  localparam logic [2:0] A_TLOAD = 3'd4;
  localparam logic [2:0] A_TCTRL = 3'd5;

  typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 w_latch;
  logic [NUM_SRC-1:0]   r_pend;
  logic [NUM_SRC-1:0]   r_mask;
  logic [TMR_W-1:0]     r_tload;
  logic [TMR_W-1:0]     r_cnt;
  logic                 r_ten;
  logic [NUM_SRC-2:0]   r_sync1;
  logic [NUM_SRC-2:0]   r_sync2;
  logic [NUM_SRC-2:0]   r_hist;
  logic                 r_intr;
  logic [VEC_W-1:0]     r_vector;

  logic                 w_wr;
  logic [2:0]           w_sel;
  logic                 w_tmr_set;
  logic [NUM_SRC-1:0]   w_set;
  logic [NUM_SRC-1:0]   w_clr;
  logic [NUM_SRC-1:0]   w_ack_clr;
  logic [NUM_SRC-1:0]   w_act;
  logic [VEC_W-1:0]     w_win;
  logic [31:0]          w_rdata;
  logic                 w_unused;

  assign w_wr      = io_cs & io_wr;
  assign w_sel     = addr[4:2];
  assign w_tmr_set = r_ten && (r_cnt == '0);
  assign w_set     = {r_sync2 & ~r_hist, w_tmr_set};
  assign w_ack_clr = (r_state == REQ && int_ack) ? (NUM_SRC'(1) << r_vector) : '0;
  assign w_clr     = ((w_wr && w_sel == A_CLR) ? D_in_IO[NUM_SRC-1:0] : '0) | w_ack_clr;
  assign w_act     = r_pend & r_mask;
  assign w_unused  = ^{addr[31:5], addr[1:0], D_in_IO};

  assign intr     = r_intr;
  assign vector   = r_vector;
  assign D_out_IO = (io_cs && io_rd) ? w_rdata : 'z;

  // Lowest pending-and-enabled index wins
  always_comb begin
    w_win = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (w_act[i]) w_win = VEC_W'(i);
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_sel)
      A_PEND:  w_rdata = 32'(r_pend);
      A_MASK:  w_rdata = 32'(r_mask);
      A_VEC:   w_rdata = 32'(r_vector);
      A_TLOAD: w_rdata = 32'(r_tload);
      A_TCTRL: w_rdata = 32'(r_ten);
      default: w_rdata = '0;
    endcase
  end

  // Synchroniser, edge history, pending and software-visible registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_hist  <= '0;
      r_pend  <= '0;
      r_mask  <= '0;
      r_tload <= '0;
      r_ten   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= irq_in;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
      r_pend  <= (r_pend & ~w_clr) | w_set;
      if (w_wr && w_sel == A_MASK)  r_mask  <= D_in_IO[NUM_SRC-1:0];
      if (w_wr && w_sel == A_TLOAD) r_tload <= D_in_IO[TMR_W-1:0];
      if (w_wr && w_sel == A_TCTRL) r_ten   <= D_in_IO[0];
      // Enabling from off primes the count; otherwise count down and wrap to TLOAD
      if (w_wr && w_sel == A_TCTRL && D_in_IO[0] && !r_ten) begin
        r_cnt <= r_tload;
      end else if (r_ten) begin
        r_cnt <= (r_cnt == '0) ? r_tload : r_cnt - TMR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_intr   <= 1'b0;
      r_vector <= '0;
    end else begin
      r_state <= w_next;
      r_intr  <= (w_next == REQ);
      if (w_latch) r_vector <= w_win;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_latch = 1'b0;
    case (r_state)
      IDLE: begin
        if (|w_act) begin
          w_latch = 1'b1;
          w_next  = REQ;
        end
      end
      REQ:     if (int_ack) w_next = SERV;
      SERV:    if (!int_ack) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_io_intr_ctrl.sv
// Directed bench for io_intr_ctrl: register-access vector table plus hand-written interrupt sequences.
module tb_io_intr_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        io_cs, io_rd, io_wr;
  logic [31:0] addr, d_in;
  wire  [31:0] d_out;
  logic [6:0]  irq_in;
  logic        int_ack;
  logic        intr;
  logic [4:0]  vector;

  int n_vec = 0;
  int n_err = 0;

  io_intr_ctrl #(.NUM_SRC(8), .TMR_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .io_cs(io_cs), .io_rd(io_rd), .io_wr(io_wr),
    .addr(addr), .D_in_IO(d_in), .D_out_IO(d_out), .irq_in(irq_in),
    .int_ack(int_ack), .intr(intr), .vector(vector)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  localparam int N_TBL = 16;
  vec_t tbl [N_TBL];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_ne(input string nm, input logic [31:0] act, input logic [31:0] bad);
    n_vec++;
    if (act === bad) begin
      n_err++;
      $display("FAIL %s: got %h, must differ from %h at %0t", nm, act, bad, $time);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    io_cs = 1'b1; io_wr = 1'b1; addr = a; d_in = d;
    @(negedge clk);
    io_cs = 1'b0; io_wr = 1'b0; d_in = '0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] q);
    io_cs = 1'b1; io_rd = 1'b1; addr = a;
    #1 q = d_out;
    io_cs = 1'b0; io_rd = 1'b0;
  endtask

  task automatic chk_rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] q;
    rd(a, q);
    chk(nm, q, exp);
  endtask

  task automatic wait_intr(input int max, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (intr) begin
        ok = 1'b1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic ack();
    int_ack = 1'b1; tick(1);
    int_ack = 1'b0; tick(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] q;
    logic        ok;

    tbl[0]  = '{1'b0, 32'h00, 32'h0,         32'h0};
    tbl[1]  = '{1'b0, 32'h04, 32'h0,         32'h0};
    tbl[2]  = '{1'b0, 32'h0C, 32'h0,         32'h0};
    tbl[3]  = '{1'b0, 32'h14, 32'h0,         32'h0};
    tbl[4]  = '{1'b1, 32'h04, 32'hFF,        32'h0};
    tbl[5]  = '{1'b0, 32'h04, 32'h0,         32'hFF};
    tbl[6]  = '{1'b1, 32'h07, 32'hFFFF_FF0F, 32'h0};
    tbl[7]  = '{1'b0, 32'h05, 32'h0,         32'h0F};
    tbl[8]  = '{1'b1, 32'h10, 32'hABCD_1234, 32'h0};
    tbl[9]  = '{1'b0, 32'h10, 32'h0,         32'h1234};
    tbl[10] = '{1'b0, 32'h08, 32'h0,         32'h0};
    tbl[11] = '{1'b1, 32'h18, 32'hFFFF_FFFF, 32'h0};
    tbl[12] = '{1'b0, 32'h18, 32'h0,         32'h0};
    tbl[13] = '{1'b0, 32'h1C, 32'h0,         32'h0};
    tbl[14] = '{1'b1, 32'h10, 32'h0,         32'h0};
    tbl[15] = '{1'b0, 32'h10, 32'h0,         32'h0};

    reset_n = 1'b0; io_cs = 1'b0; io_rd = 1'b0; io_wr = 1'b0;
    addr = '0; d_in = '0; irq_in = '0; int_ack = 1'b0;
    tick(3);
    chk("rst_intr", 32'(intr), 32'h0);
    chk("rst_vector", 32'(vector), 32'h0);
    reset_n = 1'b1;
    tick(1);

    // Register access table
    for (int i = 0; i < N_TBL; i++) begin
      if (tbl[i].wr) begin
        wr(tbl[i].a, tbl[i].d);
      end else begin
        rd(tbl[i].a, q);
        n_vec++;
        if (q !== tbl[i].exp) begin
          n_err++;
          $display("FAIL tbl[%0d] rd %h: got %h, expected %h", i, tbl[i].a, q, tbl[i].exp);
        end
      end
    end
    chk("rst_intr_after_tbl", 32'(intr), 32'h0);

    // Bus released when not selected for read (MASK holds 0x0F here)
    io_cs = 1'b0; io_rd = 1'b1; addr = 32'h04;
    #1 chk_ne("rd_no_cs", d_out, 32'h0F);
    io_cs = 1'b1; io_rd = 1'b0;
    #1 chk_ne("rd_no_rd", d_out, 32'h0F);
    io_cs = 1'b0;
    wr(32'h04, 32'h0);

    // Single external request on source 2
    wr(32'h04, 32'h04);
    irq_in = 7'b0000010;
    tick(2);
    chk_rd("t2_pend_e2", 32'h00, 32'h0);
    tick(1);
    chk_rd("t2_pend_e3", 32'h00, 32'h04);
    tick(2);
    chk("t2_intr", 32'(intr), 32'h1);
    chk("t2_vector", 32'(vector), 32'd2);
    irq_in = '0;
    int_ack = 1'b1;
    tick(1);
    chk("t2_intr_ack", 32'(intr), 32'h0);
    chk_rd("t2_pend_ack", 32'h00, 32'h0);
    tick(2);
    chk("t2_intr_serv", 32'(intr), 32'h0);
    int_ack = 1'b0;
    tick(1);
    chk("t2_vec_hold", 32'(vector), 32'd2);
    chk_rd("t2_vec_reg", 32'h0C, 32'd2);

    // Priority: sources 7 and 3 together, then a late source 1 during REQ
    wr(32'h04, 32'hFF);
    irq_in = 7'b1000100;
    tick(4);
    chk("t3_intr", 32'(intr), 32'h1);
    chk("t3_vec3", 32'(vector), 32'd3);
    chk_rd("t3_pend", 32'h00, 32'h88);
    int_ack = 1'b1; tick(1);
    chk("t3_intr_ack", 32'(intr), 32'h0);
    chk_rd("t3_pend_ack", 32'h00, 32'h80);
    int_ack = 1'b0; tick(1);
    chk("t3_idle_gap", 32'(intr), 32'h0);
    tick(1);
    chk("t3_intr2", 32'(intr), 32'h1);
    chk("t3_vec7", 32'(vector), 32'd7);
    irq_in = 7'b1000101;
    tick(4);
    chk_rd("t3_pend_new", 32'h00, 32'h82);
    chk("t3_vec_kept", 32'(vector), 32'd7);
    wr(32'h04, 32'h0);
    chk("t3_mask_clr_intr", 32'(intr), 32'h1);
    chk("t3_mask_clr_vec", 32'(vector), 32'd7);
    int_ack = 1'b1; tick(1);
    chk_rd("t3_pend_ack2", 32'h00, 32'h02);
    int_ack = 1'b0; tick(3);
    chk("t3_masked_idle", 32'(intr), 32'h0);
    wr(32'h08, 32'h02);
    chk_rd("t3_pend_end", 32'h00, 32'h0);
    irq_in = '0;
    tick(4);

    // Timer: TLOAD=4 gives a set every 5 cycles
    wr(32'h10, 32'h4);
    wr(32'h14, 32'h1);
    chk_rd("t4_tctrl", 32'h14, 32'h1);
    tick(4);
    chk_rd("t4_pend_w4", 32'h00, 32'h0);
    tick(1);
    chk_rd("t4_pend_w5", 32'h00, 32'h1);
    wr(32'h08, 32'h1);
    chk_rd("t4_pend_clr", 32'h00, 32'h0);
    tick(3);
    chk_rd("t4_pend_w9", 32'h00, 32'h0);
    tick(1);
    chk_rd("t4_pend_w10", 32'h00, 32'h1);
    wr(32'h04, 32'h1);
    for (int k = 0; k < 3; k++) begin
      wait_intr(20, ok);
      chk("t4_intr_seen", 32'(ok), 32'h1);
      chk("t4_vec0", 32'(vector), 32'd0);
      ack();
    end
    wr(32'h04, 32'h0);
    wr(32'h14, 32'h0);
    ack();
    wr(32'h08, 32'h1);
    tick(12);
    chk_rd("t4_tmr_off_pend", 32'h00, 32'h0);
    chk("t4_tmr_off_intr", 32'(intr), 32'h0);

    // Masked request, then clear racing a fresh edge
    irq_in = 7'b0001000;
    tick(3);
    chk_rd("t5_pend_masked", 32'h00, 32'h10);
    chk("t5_intr_masked", 32'(intr), 32'h0);
    wr(32'h08, 32'h10);
    chk_rd("t5_pend_clr", 32'h00, 32'h0);
    irq_in = '0;
    tick(4);
    irq_in = 7'b0001000;
    tick(2);
    wr(32'h08, 32'h10);
    chk_rd("t5_set_wins", 32'h00, 32'h10);
    wr(32'h04, 32'h10);
    tick(1);
    chk("t5_intr", 32'(intr), 32'h1);
    chk("t5_vec4", 32'(vector), 32'd4);

    // Reset while in REQ
    irq_in = '0;
    #2 reset_n = 1'b0;
    #1;
    chk("t6_intr_async", 32'(intr), 32'h0);
    chk("t6_vec_async", 32'(vector), 32'h0);
    chk_rd("t6_pend_rst", 32'h00, 32'h0);
    @(negedge clk);
    chk_rd("t6_mask_rst", 32'h04, 32'h0);
    reset_n = 1'b1;
    tick(10);
    chk("t6_no_intr", 32'(intr), 32'h0);
    wr(32'h04, 32'h10);
    tick(5);
    chk("t6_no_intr_mask", 32'(intr), 32'h0);
    chk_rd("t6_pend_quiet", 32'h00, 32'h0);
    irq_in = 7'b0001000;
    wait_intr(10, ok);
    chk("t6_intr_new", 32'(ok), 32'h1);
    chk("t6_vec4", 32'(vector), 32'd4);
    ack();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
